// File: rtl/aucohl_pkg.sv
// Shared types and helpers for the aucohl FIFO write arbiter.
package aucohl_pkg;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} arb_state_e;

  localparam int RR_MAXN = 16;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } rr_pick_t;

  // First requester after 'last' (wrapping modulo n); the descending loop lets the nearest one win.
  function automatic rr_pick_t rr_pick(input logic [RR_MAXN-1:0] req,
                                       input logic [3:0] last,
                                       input int n);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int k = n; k >= 1; k--) begin
      idx = (int'(last) + k) % n;
      if (req[idx]) begin
        r.hit = 1'b1;
        r.idx = 4'(idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aucohl_fifo.sv
// Synchronous FIFO with a show-ahead head word and a full-range occupancy counter.
module aucohl_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [AW-1:0] level
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_wr, do_rd;

  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;

  always_ff @(posedge clk)
    if (do_wr) mem[wptr] <= wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign empty = (cnt == '0);
  assign full  = cnt[AW];
  assign level = cnt[AW-1:0];

endmodule

// File: rtl/aucohl_fifo_wr_arbiter.sv
// N producers share one FIFO write port: round-robin grant with bounded burst locking, ID stored with data.
module aucohl_fifo_wr_arbiter
  import aucohl_pkg::*;
#(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          s_valid,
  input  logic [N*DW-1:0]       s_data,
  output logic [N-1:0]          s_ready,
  input  logic                  rd,
  output logic [DW-1:0]         rdata,
  output logic [$clog2(N)-1:0]  rid,
  output logic                  empty,
  output logic                  full,
  output logic [AW-1:0]         level
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(BURST + 1);

  arb_state_e    state, state_nx;
  logic [IW-1:0] last_id, last_nx, owner, owner_nx, sel, base;
  logic [CW-1:0] beat_cnt, beat_nx;
  logic          grant, wr, owner_vld;
  rr_pick_t      pick;

  assign owner_vld = (state == LOCKED) && s_valid[owner];

  // A dropped lock scans from owner+1 in the same cycle, so no bubble is inserted.
  always_comb begin
    base  = (state == LOCKED) ? owner : last_id;
    pick  = rr_pick(RR_MAXN'(s_valid), 4'(base), N);
    grant = pick.hit;
    sel   = IW'(pick.idx);
    if (owner_vld) begin
      grant = 1'b1;
      sel   = owner;
    end
  end

  assign wr      = grant & ~full;
  assign s_ready = wr ? (N'(1) << sel) : '0;

  always_comb begin
    state_nx = state;
    last_nx  = last_id;
    owner_nx = owner;
    beat_nx  = beat_cnt;
    if (!full) begin
      if (owner_vld) begin
        if (beat_cnt == CW'(BURST - 1)) begin
          last_nx  = owner;
          beat_nx  = '0;
          state_nx = UNLOCKED;
        end else begin
          beat_nx = beat_cnt + CW'(1);
        end
      end else begin
        if (state == LOCKED) begin
          last_nx  = owner;
          beat_nx  = '0;
          state_nx = UNLOCKED;
        end
        if (wr) begin
          owner_nx = sel;
          beat_nx  = CW'(1);
          if (BURST == 1) last_nx  = sel;
          else            state_nx = LOCKED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNLOCKED;
      last_id  <= IW'(N - 1);
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      last_id  <= last_nx;
      owner    <= owner_nx;
      beat_cnt <= beat_nx;
    end
  end

  aucohl_fifo #(.DW(DW + IW), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr),
    .wdata ({sel, s_data[sel*DW +: DW]}),
    .rd    (rd & ~empty),
    .rdata ({rid, rdata}),
    .empty (empty),
    .full  (full),
    .level (level)
  );

endmodule

// File: tb/tb_aucohl_fifo_wr_arbiter.sv
// Directed and random stimulus against a queue-based reference of the shared-FIFO arbiter.
module tb_aucohl_fifo_wr_arbiter;
  localparam int N = 4, DW = 8, AW = 4, BURST = 4, IW = 2, DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    s_valid = '0, s_ready;
  logic [N*DW-1:0] s_data = '0;
  logic            rd = 1'b0;
  logic [DW-1:0]   rdata;
  logic [IW-1:0]   rid;
  logic            empty, full;
  logic [AW-1:0]   level;

  always #5 clk = ~clk;

  aucohl_fifo_wr_arbiter #(.N(N), .DW(DW), .AW(AW), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .rd(rd), .rdata(rdata), .rid(rid), .empty(empty), .full(full), .level(level)
  );

  int n_assert = 0, n_fail = 0;

  // Reference: stored words as a queue, plus who holds the burst and how many beats it has used.
  logic [IW+DW-1:0] q[$];
  int m_owner, m_last, m_beats;
  bit m_locked;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_owner = 0; m_last = N - 1; m_beats = 0; m_locked = 0;
  endtask

  function automatic void model_pick(input logic [N-1:0] v, output bit hit, output int sel);
    int start;
    hit = 0; sel = 0;
    start = m_locked ? m_owner : m_last;
    if (m_locked && v[m_owner]) begin
      hit = 1; sel = m_owner;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (start + k) % N;
        if (!hit && v[i]) begin hit = 1; sel = i; end
      end
    end
  endfunction

  task automatic cyc(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic r,
                     output logic [N-1:0] rdy);
    bit hit, can_wr;
    int sel;
    logic [N-1:0] exp_rdy;
    s_valid = v; s_data = d; rd = r;
    #2;
    model_pick(v, hit, sel);
    can_wr  = hit && (q.size() < DEPTH);
    exp_rdy = can_wr ? (N'(1) << sel) : '0;
    rdy = s_ready;
    chk("s_ready", s_ready, exp_rdy);
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("level", level, q.size() % DEPTH);
    if (q.size() > 0) begin
      chk("rdata", rdata, q[0][DW-1:0]);
      chk("rid", rid, q[0][IW+DW-1:DW]);
    end
    @(posedge clk);
    if (q.size() < DEPTH) begin
      if (m_locked && v[m_owner]) begin
        m_beats++;
        if (m_beats == BURST) begin m_locked = 0; m_last = m_owner; m_beats = 0; end
      end else begin
        if (m_locked) begin m_locked = 0; m_last = m_owner; m_beats = 0; end
        if (can_wr) begin
          m_owner = sel; m_beats = 1;
          if (BURST == 1) m_last = sel; else m_locked = 1;
        end
      end
    end
    if (r && q.size() > 0) void'(q.pop_front());
    if (can_wr) q.push_back({IW'(sel), d[sel*DW +: DW]});
    #1;
  endtask

  task automatic do_reset();
    s_valid = '0; rd = 1'b0; rst_n = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] rdy;
    model_reset();
    #1;

    // Single word from producer 2
    do_reset();
    cyc(4'b0100, 32'h005A_0000, 1'b0, rdy);
    chk("t1_rdy", rdy, 4'b0100);
    chk("t1_empty", empty, 0);
    chk("t1_level", level, 1);
    chk("t1_rdata", rdata, 8'h5A);
    chk("t1_rid", rid, 2);
    cyc(4'b0000, '0, 1'b0, rdy);

    // Everyone valid: bursts of four, fill to full
    do_reset();
    for (int i = 0; i < 16; i++) cyc(4'hF, $urandom, 1'b0, rdy);
    chk("t2_full", full, 1);
    chk("t2_level", level, 0);

    // Full with rd: ready stays closed during the pop, opens the next cycle
    cyc(4'b0001, $urandom, 1'b1, rdy);
    chk("t4_rd_cycle_rdy", rdy, 4'b0000);
    cyc(4'b0001, $urandom, 1'b0, rdy);
    chk("t4_next_rdy", rdy, 4'b0001);
    chk("t4_full", full, 1);
    chk("t4_level", level, 0);
    for (int j = 0; j < 16; j++) begin
      chk("t2_order", rid, (j < 15) ? (j + 1) / 4 : 0);
      cyc(4'b0000, '0, 1'b1, rdy);
    end
    chk("t2_drained", empty, 1);

    // Owner drops mid-burst: another producer is granted in the same cycle
    do_reset();
    cyc(4'b0010, $urandom, 1'b0, rdy);
    cyc(4'b0010, $urandom, 1'b0, rdy);
    cyc(4'b1000, $urandom, 1'b0, rdy);
    chk("t3_handover", rdy, 4'b1000);
    cyc(4'b0101, $urandom, 1'b0, rdy);
    chk("t3_scan_from_0", rdy, 4'b0001);

    // Reads on an empty FIFO are ignored
    do_reset();
    for (int i = 0; i < 3; i++) cyc(4'b0000, '0, 1'b1, rdy);
    chk("t5_empty", empty, 1);
    chk("t5_level", level, 0);
    cyc(4'b0010, 32'h0000_3300, 1'b0, rdy);
    chk("t5_rdata", rdata, 8'h33);
    chk("t5_rid", rid, 1);
    chk("t5_level1", level, 1);

    // Reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 5; i++) cyc(4'b0011, $urandom, 1'b0, rdy);
    chk("t6_level5", level, 5);
    do_reset();
    cyc(4'hF, $urandom, 1'b0, rdy);
    chk("t6_first_grant", rdy, 4'b0001);

    // Random traffic: a fill-heavy phase then a balanced phase
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      logic r;
      r = (i < 600) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      cyc(4'($urandom_range(0, 15)), $urandom, r, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/aucohl_fifo_wr_arbiter.md
Name: aucohl_fifo_wr_arbiter

Overview:
Shares one aucohl_fifo write port among N producers using round-robin arbitration with bounded burst locking. Each accepted word is stored together with the index of the producer that wrote it. The single consumer drains the FIFO and gets both the data and its source ID. The block sits between several peripheral producers (e.g. per-channel samplers) and one drain engine.

Parameters:
N, 4, number of producers; legal range 2..16
DW, 8, data width per producer
AW, 4, FIFO address width; depth = 2**AW
BURST, 4, maximum consecutive beats one producer may hold the grant; legal range >= 1
IW (localparam), $clog2(N), source-ID width

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  N  producer i has a word pending
s_data  input  N*DW  word of producer i at [i*DW +: DW]
s_ready  output  N  one-hot or zero; producer i's word is accepted when s_valid[i] & s_ready[i] at a clock edge
rd  input  1  consumer pop request
rdata  output  DW  data at FIFO head
rid  output  IW  source ID at FIFO head
empty  output  1  FIFO empty
full  output  1  FIFO full
level  output  AW  FIFO occupancy (modulo 2**AW)

Behaviour:
- Reset (async, rst_n=0): last_id=N-1, owner=0, locked=0, beat_cnt=0. FIFO is empty. Outputs: s_ready=0, empty=1, full=0, level=0. rdata/rid are undefined until the first write.
- Registered state: last_id (IW), owner (IW), locked (1), beat_cnt (clog2(BURST+1)).
- Grant selection is combinational, with zero latency from s_valid to s_ready:
  - If locked & s_valid[owner]: sel=owner.
  - Otherwise: sel = first i with s_valid[i]=1, scanning last_id+1, last_id+2, ... with wrap modulo N.
  - If no requester is valid: no grant.
- s_ready[sel] = ~full. All other s_ready bits are 0. s_ready never depends on rd.
- Write: wr = |(s_valid & s_ready). The FIFO stores {sel, s_data[sel]}, width DW+IW.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED, write by sel: owner<=sel, beat_cnt<=1.
    - If BURST==1: last_id<=sel and stay UNLOCKED.
    - Else: go to LOCKED.
  - LOCKED, write: beat_cnt<=beat_cnt+1.
    - If beat_cnt+1==BURST: last_id<=owner, go to UNLOCKED, beat_cnt<=0.
  - LOCKED, s_valid[owner]=0: release in the same cycle with no bubble. last_id<=owner, beat_cnt<=0, go to UNLOCKED. If another producer is valid in this cycle, it is granted this cycle via the round-robin scan from owner+1 (which equals the new last_id). Its write, if it happens, updates owner, beat_cnt and state as in the UNLOCKED case.
  - LOCKED, s_valid[owner]=1, full=1: hold all state (lock is kept while stalled).
- Pop: the FIFO rd input is rd & ~empty. A rd while empty is ignored and no pointer moves. rd and a write in the same cycle are both performed and level is unchanged.
- Full: s_ready=0 and no state changes except from the rd path. A simultaneous rd does not open s_ready in that cycle. The write happens in the next cycle once full=0.
- Level wrap: level is AW bits. When the FIFO holds exactly 2**AW words, level=0 and full=1. Consumers must qualify level with full.
- rdata/rid show the head word combinationally (show-ahead). They are valid whenever empty=0.
- A reset asserted mid-burst aborts the lock and flushes the FIFO immediately.

Decomposition:
- Shared package aucohl_pkg holds:
  - arbiter state encoding UNLOCKED=1'b0, LOCKED=1'b1;
  - a function returning the round-robin index (mask and priority scan).
- Natural sub-module: one aucohl_fifo instance with DW=DW+IW and AW=AW. Data is packed {id, data}, with the ID in the MSBs.
- The arbiter and lock FSM stay in the top module.

Test Plan:
- Reset, then producer 2 sends a single word 0x5A with rd=0 → s_ready=4'b0100 in the same cycle; next cycle empty=0, level=1, rdata=0x5A, rid=2.
- All four producers hold valid continuously, BURST=4, rd=0 → accepted order is 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3; full=1 after 16 writes, level=0, s_ready=0.
- Producer 1 in LOCKED state drops valid after 2 beats while producer 3 is valid → in that same cycle s_ready=4'b1000 with no idle cycle; next arbitration scan starts at 0.
- FIFO full with producer 0 valid; assert rd for one cycle → s_ready stays 0 in the rd cycle; the next cycle has s_ready[0]=1 and the write lands; level returns to 0 with full=1.
- Empty FIFO, rd=1 for 3 cycles with no writes → empty stays 1, level stays 0; the next write is read back correctly (no pointer corruption).
- Assert rst_n low mid-burst with level=5 → immediately empty=1, level=0, s_ready=0; after release, the first grant goes to producer 0.
